rf_wb_scheduler: RTL and testbench

//  Sequences the register file: shares its single write port between the ALU and LSU writeback

---
 rtl/rf_wb_scheduler_pkg.sv | 17 +
 rtl/rf_wb_scheduler_rr_arb2.sv | 37 +++
 rtl/rf_wb_scheduler.sv | 138 +++++++++++++
 tb/tb_rf_wb_scheduler.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_scheduler_pkg.sv
// Shared constants and types for the register-file writeback scheduler.
//   RF_DATA_W : register data width
//   RF_AW     : register index width
//   RF_NREG   : architectural register count (2**RF_AW), r0 hard-wired to zero
//   src_e     : writeback source encoding, also used as the round-robin pointer value
package rf_wb_scheduler_pkg;

  localparam int RF_DATA_W = 16;
  localparam int RF_AW     = 4;
  localparam int RF_NREG   = 16;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

endpackage

// File: rtl/rf_wb_scheduler_rr_arb2.sv
// Two-way round-robin arbiter for the regfile write port.
//   clk, rst_n : clock, async active-low reset (pointer returns to ALU)
//   i_req[1:0] : request, bit 0 = ALU, bit 1 = LSU
//   o_gnt[1:0] : one-hot grant, same bit order (combinational)
// A lone requester is always granted. When both request, the pointer picks the
// winner and then flips to the loser, so neither source trails by more than a cycle.
module rr_arb2
  import rf_wb_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  src_e r_ptr;

  always_comb begin
    o_gnt = 2'b00;
    unique case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = (r_ptr == SRC_ALU) ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

  // The pointer only moves on a contested cycle; uncontested grants leave it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= SRC_ALU;
    end else if (&i_req) begin
      r_ptr <= (r_ptr == SRC_ALU) ? SRC_LSU : SRC_ALU;
    end
  end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Register-file writeback scheduler: shares the single regfile write port between
// the ALU and LSU, and tracks in-flight writes in a busy scoreboard that stalls issue.
//   clk, rst_n                       : clock, async active-low reset
//   iss_valid/rs1/rs2/rd/wr          : instruction offered for issue
//   iss_stall                        : issue blocked this cycle (combinational)
//   alu_valid/rd/data, alu_ready     : ALU writeback handshake
//   lsu_valid/rd/data, lsu_ready     : LSU writeback handshake
//   rf_reg_write/rf_rd/rf_rd_data    : registered regfile write port
//   busy_vec, pend_cnt               : scoreboard bits and their population count
//   wb_err                           : sticky, writeback landed on a non-busy register
module rf_wb_scheduler
  import rf_wb_scheduler_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int AW     = RF_AW,
  parameter int NREG   = RF_NREG
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rs1,
  input  logic [AW-1:0]     iss_rs2,
  input  logic [AW-1:0]     iss_rd,
  input  logic              iss_wr,
  output logic              iss_stall,
  input  logic              alu_valid,
  input  logic [AW-1:0]     alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              lsu_valid,
  input  logic [AW-1:0]     lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              lsu_ready,
  output logic              rf_reg_write,
  output logic [AW-1:0]     rf_rd,
  output logic [DATA_W-1:0] rf_rd_data,
  output logic [NREG-1:0]   busy_vec,
  output logic [AW:0]       pend_cnt,
  output logic              wb_err
);

  logic              r_rf_we;
  logic [AW-1:0]     r_rf_rd;
  logic [DATA_W-1:0] r_rf_data;
  logic [NREG-1:0]   r_busy;
  logic [AW:0]       r_pend;
  logic              r_wb_err;

  logic [1:0]        w_gnt;
  logic              w_wb_vld;
  logic [AW-1:0]     w_wb_rd;
  logic [DATA_W-1:0] w_wb_data;
  logic              w_wb_nz;
  logic              w_rs1_haz;
  logic              w_rs2_haz;
  logic              w_rd_haz;
  logic              w_iss_set;
  logic              w_err_set;
  logic [NREG-1:0]   w_busy_nxt;
  logic [AW:0]       w_pend_nxt;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .i_req ({lsu_valid, alu_valid}),
    .o_gnt (w_gnt)
  );

  assign alu_ready = w_gnt[0];
  assign lsu_ready = w_gnt[1];

  assign w_wb_vld  = |w_gnt;
  assign w_wb_rd   = w_gnt[1] ? lsu_rd   : alu_rd;
  assign w_wb_data = w_gnt[1] ? lsu_data : alu_data;
  assign w_wb_nz   = w_wb_vld && (w_wb_rd != '0);

  // A register being written this cycle is not a hazard: the regfile forwards
  // the write data to its read ports in the same cycle.
  assign w_rs1_haz = (iss_rs1 != '0) && r_busy[iss_rs1] && !(r_rf_we && (r_rf_rd == iss_rs1));
  assign w_rs2_haz = (iss_rs2 != '0) && r_busy[iss_rs2] && !(r_rf_we && (r_rf_rd == iss_rs2));
  assign w_rd_haz  = (iss_rd  != '0) && r_busy[iss_rd]  && !(r_rf_we && (r_rf_rd == iss_rd));

  assign iss_stall = iss_valid && (w_rs1_haz || w_rs2_haz || (iss_wr && w_rd_haz));
  assign w_iss_set = iss_valid && !iss_stall && iss_wr && (iss_rd != '0);

  // A writeback to a register that is neither busy nor being claimed right now
  // has no matching issue behind it.
  assign w_err_set = w_wb_nz && !r_busy[w_wb_rd] && !(w_iss_set && (iss_rd == w_wb_rd));

  // Clear first, then set, so a same-index collision leaves the bit set.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_rf_we) begin
      w_busy_nxt[r_rf_rd] = 1'b0;
    end
    if (w_iss_set) begin
      w_busy_nxt[iss_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_comb begin
    w_pend_nxt = '0;
    for (int i = 0; i < NREG; i++) begin
      w_pend_nxt = w_pend_nxt + {{AW{1'b0}}, w_busy_nxt[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf_we   <= 1'b0;
      r_rf_rd   <= '0;
      r_rf_data <= '0;
      r_busy    <= '0;
      r_pend    <= '0;
      r_wb_err  <= 1'b0;
    end else begin
      r_rf_we <= w_wb_nz;
      if (w_wb_nz) begin
        r_rf_rd   <= w_wb_rd;
        r_rf_data <= w_wb_data;
      end
      r_busy <= w_busy_nxt;
      r_pend <= w_pend_nxt;
      if (w_err_set) begin
        r_wb_err <= 1'b1;
      end
    end
  end

  assign rf_reg_write = r_rf_we;
  assign rf_rd        = r_rf_rd;
  assign rf_rd_data   = r_rf_data;
  assign busy_vec     = r_busy;
  assign pend_cnt     = r_pend;
  assign wb_err       = r_wb_err;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
module tb_rf_wb_scheduler;
  import rf_wb_scheduler_pkg::*;

  localparam int DW = RF_DATA_W;
  localparam int AW = RF_AW;
  localparam int NR = RF_NREG;

  logic          clk;
  logic          rst_n;
  logic          iss_valid;
  logic [AW-1:0] iss_rs1;
  logic [AW-1:0] iss_rs2;
  logic [AW-1:0] iss_rd;
  logic          iss_wr;
  logic          iss_stall;
  logic          alu_valid;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          alu_ready;
  logic          lsu_valid;
  logic [AW-1:0] lsu_rd;
  logic [DW-1:0] lsu_data;
  logic          lsu_ready;
  logic          rf_reg_write;
  logic [AW-1:0] rf_rd;
  logic [DW-1:0] rf_rd_data;
  logic [NR-1:0] busy_vec;
  logic [AW:0]   pend_cnt;
  logic          wb_err;

  rf_wb_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .iss_valid    (iss_valid),
    .iss_rs1      (iss_rs1),
    .iss_rs2      (iss_rs2),
    .iss_rd       (iss_rd),
    .iss_wr       (iss_wr),
    .iss_stall    (iss_stall),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .alu_ready    (alu_ready),
    .lsu_valid    (lsu_valid),
    .lsu_rd       (lsu_rd),
    .lsu_data     (lsu_data),
    .lsu_ready    (lsu_ready),
    .rf_reg_write (rf_reg_write),
    .rf_rd        (rf_rd),
    .rf_rd_data   (rf_rd_data),
    .busy_vec     (busy_vec),
    .pend_cnt     (pend_cnt),
    .wb_err       (wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic push_wr(input logic [AW-1:0] rd, input logic [DW-1:0] data);
    wr_t e;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Waits (bounded) for the next regfile write and compares it with the oldest expected entry.
  task automatic wait_write(input string tag);
    wr_t e;
    bit  seen;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      if (rf_reg_write === 1'b1) seen = 1'b1;
    end
    chk({tag, "_we"}, 32'(rf_reg_write), 32'd1);
    if (seen) begin
      e = exp_q.pop_front();
      chk({tag, "_rd"},   32'(rf_rd),      32'(e.rd));
      chk({tag, "_data"}, 32'(rf_rd_data), 32'(e.data));
    end
  endtask

  task automatic drive_iss(input logic v, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                           input logic [AW-1:0] rs2, input logic wr);
    iss_valid = v;
    iss_rd    = rd;
    iss_rs1   = rs1;
    iss_rs2   = rs2;
    iss_wr    = wr;
  endtask

  // Issues a hazard-free writing instruction; returns one cycle later with issue idle.
  task automatic issue_wr(input logic [AW-1:0] rd);
    drive_iss(1'b1, rd, '0, '0, 1'b1);
    smp();
    chk("issue_nostall", 32'(iss_stall), 32'd0);
    tick();
    iss_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    drive_iss(1'b0, '0, '0, '0, 1'b0);
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;

    #12;
    chk("rst_busy",  32'(busy_vec),     32'h0);
    chk("rst_pend",  32'(pend_cnt),     32'h0);
    chk("rst_we",    32'(rf_reg_write), 32'h0);
    chk("rst_rd",    32'(rf_rd),        32'h0);
    chk("rst_data",  32'(rf_rd_data),   32'h0);
    chk("rst_err",   32'(wb_err),       32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: reset in the middle of a writeback sequence
    issue_wr(4'd1);
    issue_wr(4'd2);
    smp();
    chk("t1_busy", 32'(busy_vec), 32'h0006);
    chk("t1_pend", 32'(pend_cnt), 32'd2);
    tick();
    alu_valid = 1'b1; alu_rd = 4'd1; alu_data = 16'hA1A1;
    lsu_valid = 1'b1; lsu_rd = 4'd2; lsu_data = 16'hB2B2;
    push_wr(4'd1, 16'hA1A1);
    smp();
    chk("t1_alu_rdy", 32'(alu_ready), 32'd1);
    chk("t1_lsu_rdy", 32'(lsu_ready), 32'd0);
    tick();
    alu_valid = 1'b0;
    wait_write("t1_r1");
    chk("t1_busy_pre", 32'(busy_vec), 32'h0006);
    rst_n = 1'b0;
    #1;
    chk("t1_async_busy",  32'(busy_vec),     32'h0);
    chk("t1_async_pend",  32'(pend_cnt),     32'h0);
    chk("t1_async_we",    32'(rf_reg_write), 32'h0);
    chk("t1_async_rd",    32'(rf_rd),        32'h0);
    chk("t1_async_data",  32'(rf_rd_data),   32'h0);
    chk("t1_async_err",   32'(wb_err),       32'h0);
    chk("t1_async_stall", 32'(iss_stall),    32'h0);
    lsu_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    alu_valid = 1'b1; alu_rd = '0; alu_data = 16'h1111;
    lsu_valid = 1'b1; lsu_rd = '0; lsu_data = 16'h2222;
    smp();
    chk("t1_first_alu", 32'(alu_ready), 32'd1);
    chk("t1_first_lsu", 32'(lsu_ready), 32'd0);
    tick();
    smp();
    chk("t1_second_lsu", 32'(lsu_ready), 32'd1);
    chk("t1_second_alu", 32'(alu_ready), 32'd0);
    chk("t5_r0_we_a",    32'(rf_reg_write), 32'd0);
    tick();
    alu_valid = 1'b0; lsu_valid = 1'b0;
    smp();
    chk("t5_r0_we_b", 32'(rf_reg_write), 32'd0);
    chk("t5_r0_err",  32'(wb_err),       32'd0);
    tick();

    // 2: contention, ALU first, LSU next cycle
    issue_wr(4'd3);
    issue_wr(4'd4);
    smp();
    chk("t2_busy", 32'(busy_vec), 32'h0018);
    chk("t2_pend", 32'(pend_cnt), 32'd2);
    tick();
    alu_valid = 1'b1; alu_rd = 4'd3; alu_data = 16'h3333;
    lsu_valid = 1'b1; lsu_rd = 4'd4; lsu_data = 16'h4444;
    push_wr(4'd3, 16'h3333);
    push_wr(4'd4, 16'h4444);
    smp();
    chk("t2_n_alu", 32'(alu_ready), 32'd1);
    chk("t2_n_lsu", 32'(lsu_ready), 32'd0);
    tick();
    alu_rd = '0; alu_data = 16'h0;
    wait_write("t2_r3");
    chk("t2_n1_lsu", 32'(lsu_ready), 32'd1);
    chk("t2_n1_alu", 32'(alu_ready), 32'd0);
    tick();
    lsu_valid = 1'b0;
    wait_write("t2_r4");
    chk("t2_alone_alu", 32'(alu_ready), 32'd1);
    chk("t2_busy_mid",  32'(busy_vec),  32'h0010);
    tick();
    alu_valid = 1'b0;
    smp();
    chk("t2_busy_end", 32'(busy_vec),     32'h0);
    chk("t2_pend_end", 32'(pend_cnt),     32'd0);
    chk("t2_r0_we",    32'(rf_reg_write), 32'd0);
    tick();
    alu_valid = 1'b1; alu_rd = '0;
    lsu_valid = 1'b1; lsu_rd = '0;
    smp();
    chk("t2_next_alu", 32'(alu_ready), 32'd1);
    chk("t2_next_lsu", 32'(lsu_ready), 32'd0);
    tick();
    alu_valid = 1'b0; lsu_valid = 1'b0;

    // 3: RAW stall released by the write-cycle bypass
    issue_wr(4'd5);
    drive_iss(1'b1, '0, 4'd5, '0, 1'b0);
    smp();
    chk("t3_stall_a", 32'(iss_stall), 32'd1);
    tick();
    smp();
    chk("t3_stall_b", 32'(iss_stall), 32'd1);
    tick();
    alu_valid = 1'b1; alu_rd = 4'd5; alu_data = 16'h5555;
    push_wr(4'd5, 16'h5555);
    smp();
    chk("t3_stall_c", 32'(iss_stall), 32'd1);
    chk("t3_alu_rdy", 32'(alu_ready), 32'd1);
    tick();
    alu_valid = 1'b0;
    wait_write("t3_r5");
    chk("t3_bypass",    32'(iss_stall), 32'd0);
    chk("t3_busy_wcyc", 32'(busy_vec),  32'h0020);
    tick();
    iss_valid = 1'b0;
    smp();
    chk("t3_busy_after", 32'(busy_vec), 32'h0);
    tick();

    // 4: set/clear collision on r7, then WAW and rs2 hazards
    issue_wr(4'd7);
    smp();
    chk("t4_busy", 32'(busy_vec), 32'h0080);
    chk("t4_pend", 32'(pend_cnt), 32'd1);
    tick();
    alu_valid = 1'b1; alu_rd = 4'd7; alu_data = 16'h7777;
    push_wr(4'd7, 16'h7777);
    smp();
    chk("t4_alu_rdy", 32'(alu_ready), 32'd1);
    tick();
    alu_valid = 1'b0;
    drive_iss(1'b1, 4'd7, '0, '0, 1'b1);
    wait_write("t4_r7");
    chk("t4_nostall", 32'(iss_stall), 32'd0);
    tick();
    iss_valid = 1'b0;
    smp();
    chk("t4_busy_kept", 32'(busy_vec), 32'h0080);
    chk("t4_pend_kept", 32'(pend_cnt), 32'd1);
    chk("t4_err",       32'(wb_err),   32'd0);
    tick();
    drive_iss(1'b1, '0, '0, 4'd7, 1'b0);
    smp();
    chk("t4_rs2_haz", 32'(iss_stall), 32'd1);
    tick();
    drive_iss(1'b1, 4'd7, '0, '0, 1'b1);
    smp();
    chk("t4_waw_haz", 32'(iss_stall), 32'd1);
    tick();
    drive_iss(1'b1, 4'd7, '0, '0, 1'b0);
    smp();
    chk("t4_rd_nowr", 32'(iss_stall), 32'd0);
    tick();
    iss_valid = 1'b0;

    // 5: r0 is never busy and never written
    drive_iss(1'b1, '0, '0, '0, 1'b1);
    smp();
    chk("t5_r0_stall", 32'(iss_stall), 32'd0);
    tick();
    iss_valid = 1'b0;
    smp();
    chk("t5_r0_busy", 32'(busy_vec), 32'h0080);
    tick();
    lsu_valid = 1'b1; lsu_rd = '0; lsu_data = 16'hDEAD;
    smp();
    chk("t5_lsu_rdy", 32'(lsu_ready), 32'd1);
    tick();
    lsu_valid = 1'b0;
    smp();
    chk("t5_lsu_r0_we",  32'(rf_reg_write), 32'd0);
    chk("t5_lsu_r0_err", 32'(wb_err),       32'd0);
    tick();

    // 6: writeback to a non-busy register sets the sticky error
    lsu_valid = 1'b1; lsu_rd = 4'd9; lsu_data = 16'h9999;
    push_wr(4'd9, 16'h9999);
    smp();
    chk("t6_lsu_rdy", 32'(lsu_ready), 32'd1);
    chk("t6_err_pre", 32'(wb_err),    32'd0);
    tick();
    lsu_valid = 1'b0;
    wait_write("t6_r9");
    chk("t6_err_set", 32'(wb_err), 32'd1);
    repeat (3) tick();
    smp();
    chk("t6_err_sticky", 32'(wb_err),   32'd1);
    chk("t6_busy",       32'(busy_vec), 32'h0080);
    rst_n = 1'b0;
    #1;
    chk("t6_err_rst",  32'(wb_err),   32'd0);
    chk("t6_busy_rst", 32'(busy_vec), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
